// File: rtl/au_pkg.sv
// Shared types and helpers for the arithmetic-unit library serial blocks.
package au_pkg;

  // Control states of the digit-serial arithmetic units.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } au_sub_state_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int au_clog2(input int value);
    int result;
    result = 0;
    while ((32'd1 << result) < value) begin
      result = result + 32'd1;
    end
    if (result < 1) begin
      result = 1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/au_sub_digit.sv
// One-digit subtract slice: {bo_d, d_d} = x - y - bi_d.
module au_sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bi_d,
  output logic [DIGIT-1:0] d_d,
  output logic             bo_d
);

  // One extra bit catches the borrow: any negative result sets the top bit.
  logic [DIGIT:0] diff;

  assign diff = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bi_d};
  assign d_d  = diff[DIGIT-1:0];
  assign bo_d = diff[DIGIT];

endmodule

// File: rtl/au_sub_b_ser.sv
// Digit-serial subtractor with borrow-in/borrow-out, LSB digit first.
// Optional signed-overflow output enabled by defining AU_SUB_B_SER_OVF_EN.
module au_sub_b_ser
  import au_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef AU_SUB_B_SER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
  localparam int CW = au_clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if ((DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
      $error("au_sub_b_ser: WIDTH must be a positive multiple of DIGIT");
    end
  endgenerate

  au_sub_state_t    state_r;
  au_sub_state_t    state_nx;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             borrow_r;
  logic [WIDTH-1:0] d_r;
  logic             bo_r;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] d_dig;
  logic             bo_dig;

  // Current digit of the latched operands, selected by the digit counter.
  assign a_dig = a_r[cnt_r*DIGIT +: DIGIT];
  assign b_dig = b_r[cnt_r*DIGIT +: DIGIT];

  au_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .x    (a_dig),
    .y    (b_dig),
    .bi_d (borrow_r),
    .d_d  (d_dig),
    .bo_d (bo_dig)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Next-state decode; in IDLE in_ready is 1 so in_valid alone means accept.
  always_comb begin
    state_nx = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) state_nx = RUN;
        else          state_nx = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST) state_nx = DONE;
        else               state_nx = RUN;
      end
      DONE: begin
        if (out_ready) state_nx = IDLE;
        else           state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture on accept, then one digit per RUN cycle into the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      borrow_r <= 1'b0;
      d_r      <= '0;
      bo_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= bi;
            cnt_r    <= '0;
          end
        end
        RUN: begin
          d_r[cnt_r*DIGIT +: DIGIT] <= d_dig;
          borrow_r                  <= bo_dig;
          if (cnt_r == LAST) begin
            bo_r  <= bo_dig;
            cnt_r <= '0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef AU_SUB_B_SER_OVF_EN
  logic ovf_r;

  // Signed overflow, captured together with the top digit of the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if ((state_r == RUN) && (cnt_r == LAST)) begin
      ovf_r <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (d_dig[DIGIT-1] != a_r[WIDTH-1]);
    end
  end

  assign ovf = ovf_r;
`endif

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign d         = d_r;
  assign bo        = bo_r;

endmodule

// File: tb/tb_au_sub_b_ser.sv
// Self-checking bench for au_sub_b_ser: an 8/4 instance for the main tests,
// plus 32/32 and 32/1 instances for the latency extremes.
module tb_au_sub_b_ser;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // main instance: WIDTH=8, DIGIT=4
  logic       m_in_valid, m_in_ready, m_bi, m_out_valid, m_out_ready, m_bo;
  logic [7:0] m_a, m_b, m_d;
  // parallel instance: WIDTH=32, DIGIT=32
  logic        p_in_valid, p_in_ready, p_bi, p_out_valid, p_out_ready, p_bo;
  logic [31:0] p_a, p_b, p_d;
  // serial instance: WIDTH=32, DIGIT=1
  logic        s_in_valid, s_in_ready, s_bi, s_out_valid, s_out_ready, s_bo;
  logic [31:0] s_a, s_b, s_d;
`ifdef AU_SUB_B_SER_OVF_EN
  logic m_ovf, p_ovf, s_ovf;
`endif

  au_sub_b_ser #(.WIDTH(8), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .bi(m_bi), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .d(m_d), .bo(m_bo)
`ifdef AU_SUB_B_SER_OVF_EN
    , .ovf(m_ovf)
`endif
  );

  au_sub_b_ser #(.WIDTH(32), .DIGIT(32)) dut_p (
    .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .a(p_a), .b(p_b), .bi(p_bi), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .d(p_d), .bo(p_bo)
`ifdef AU_SUB_B_SER_OVF_EN
    , .ovf(p_ovf)
`endif
  );

  au_sub_b_ser #(.WIDTH(32), .DIGIT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .bi(s_bi), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .d(s_d), .bo(s_bo)
`ifdef AU_SUB_B_SER_OVF_EN
    , .ovf(s_ovf)
`endif
  );

  // Reference: full-width unsigned difference, borrow is the extra top bit.
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {8'd0, c};
  endfunction

  function automatic logic [32:0] ref32(input logic [31:0] x, input logic [31:0] y, input logic c);
    return {1'b0, x} - {1'b0, y} - {32'd0, c};
  endfunction

  // Signed overflow from operand and result sign bits.
  function automatic logic ovf_ref(input logic as, input logic bs, input logic ds);
    return (as != bs) && (ds != as);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the 8-bit instance with an out_ready stall of 'stall' cycles.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic biv,
                     input int stall, input logic [8:0] expv, input logic expo);
    int lat;
    total++;
    if (m_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL op8_idle in_ready=%b want 1", m_in_ready);
    end
    m_a = av; m_b = bv; m_bi = biv; m_in_valid = 1'b1;
    step();
    m_in_valid = 1'b0;
    m_a = 8'($urandom); m_b = 8'($urandom); m_bi = 1'($urandom);
    lat = 0;
    while (!m_out_valid && lat < 20) begin
      step();
      lat++;
    end
    total++;
    if (lat !== 2) begin
      bad++;
      $display("FAIL op8_latency got=%0d want=2", lat);
    end
    total++;
    if ({m_bo, m_d} !== expv) begin
      bad++;
      $display("FAIL op8_result a=%h b=%h bi=%b got bo,d=%h want=%h", av, bv, biv, {m_bo, m_d}, expv);
    end
`ifdef AU_SUB_B_SER_OVF_EN
    total++;
    if (m_ovf !== expo) begin
      bad++;
      $display("FAIL op8_ovf a=%h b=%h bi=%b got=%b want=%b", av, bv, biv, m_ovf, expo);
    end
`endif
    repeat (stall) step();
    total++;
    if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0 || {m_bo, m_d} !== expv) begin
      bad++;
      $display("FAIL op8_stall ov=%b ir=%b bo,d=%h want ov=1 ir=0 bo,d=%h", m_out_valid, m_in_ready, {m_bo, m_d}, expv);
    end
    m_out_ready = 1'b1;
    step();
    m_out_ready = 1'b0;
    total++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL op8_release ov=%b ir=%b want ov=0 ir=1", m_out_valid, m_in_ready);
    end
  endtask

  task automatic op8_rand(input int stall);
    logic [7:0] av, bv;
    logic       biv;
    logic [8:0] e;
    av = 8'($urandom); bv = 8'($urandom); biv = 1'($urandom);
    e = ref8(av, bv, biv);
    op8(av, bv, biv, stall, e, ovf_ref(av[7], bv[7], e[7]));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_in_valid = 1'b0; m_out_ready = 1'b0; m_a = 8'd0; m_b = 8'd0; m_bi = 1'b0;
    p_in_valid = 1'b0; p_out_ready = 1'b0; p_a = 32'd0; p_b = 32'd0; p_bi = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_a = 32'd0; s_b = 32'd0; s_bi = 1'b0;
    step();
    step();
    total++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0 || m_d !== 8'd0 || m_bo !== 1'b0) begin
      bad++;
      $display("FAIL reset_main ir=%b ov=%b d=%h bo=%b want 1 0 00 0", m_in_ready, m_out_valid, m_d, m_bo);
    end
`ifdef AU_SUB_B_SER_OVF_EN
    total++;
    if (m_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_ovf got=%b want=0", m_ovf);
    end
`endif
    total++;
    if (p_in_ready !== 1'b1 || p_out_valid !== 1'b0 || p_d !== 32'd0 || s_in_ready !== 1'b1 ||
        s_out_valid !== 1'b0 || s_d !== 32'd0 || p_bo !== 1'b0 || s_bo !== 1'b0) begin
      bad++;
      $display("FAIL reset_wide p:ir=%b ov=%b d=%h s:ir=%b ov=%b d=%h", p_in_ready, p_out_valid, p_d, s_in_ready, s_out_valid, s_d);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    op8(8'h00, 8'h01, 1'b0, 0, 9'h1FF, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1, 9'h1FF, 1'b0);
    op8(8'h80, 8'h01, 1'b0, 0, 9'h07F, 1'b1);
    op8(8'h05, 8'h03, 1'b0, 2, 9'h002, 1'b0);
    op8(8'h00, 8'h00, 1'b1, 0, 9'h1FF, 1'b0);
    op8(8'h7F, 8'hFF, 1'b0, 0, 9'h180, 1'b1);
  endtask

  task automatic test_corners();
    logic [7:0] vals [6];
    logic [8:0] e;
    vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        for (int c = 0; c < 2; c++) begin
          e = ref8(vals[i], vals[j], 1'(c));
          op8(vals[i], vals[j], 1'(c), 0, e, ovf_ref(vals[i][7], vals[j][7], e[7]));
        end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2500; i++) op8_rand(int'($urandom_range(0, 3)));
  endtask

  task automatic test_backpressure();
    logic [7:0] av, bv, nav, nbv;
    logic       biv, nbiv;
    logic [8:0] e, ne;
    int         lat;
    av = 8'($urandom); bv = 8'($urandom); biv = 1'($urandom);
    nav = 8'($urandom); nbv = 8'($urandom); nbiv = 1'($urandom);
    e = ref8(av, bv, biv);
    ne = ref8(nav, nbv, nbiv);
    m_a = av; m_b = bv; m_bi = biv; m_in_valid = 1'b1;
    step();
    m_in_valid = 1'b0;
    lat = 0;
    while (!m_out_valid && lat < 20) begin step(); lat++; end
    m_a = nav; m_b = nbv; m_bi = nbiv; m_in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      total++;
      if (m_in_ready !== 1'b0 || m_out_valid !== 1'b1 || {m_bo, m_d} !== e) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d ir=%b ov=%b bo,d=%h want 0 1 %h", k, m_in_ready, m_out_valid, {m_bo, m_d}, e);
      end
    end
    m_out_ready = 1'b1;
    step();
    m_out_ready = 1'b0;
    total++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_idle ir=%b ov=%b want 1 0", m_in_ready, m_out_valid);
    end
    step();
    m_in_valid = 1'b0;
    total++;
    if (m_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_accept ir=%b want 0", m_in_ready);
    end
    lat = 0;
    while (!m_out_valid && lat < 20) begin step(); lat++; end
    total++;
    if (lat !== 2 || {m_bo, m_d} !== ne) begin
      bad++;
      $display("FAIL bp_second lat=%0d bo,d=%h want lat=2 bo,d=%h", lat, {m_bo, m_d}, ne);
    end
    m_out_ready = 1'b1;
    step();
    m_out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    m_a = 8'h12; m_b = 8'h34; m_bi = 1'b1; m_in_valid = 1'b1;
    step();
    m_in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_d !== 8'd0 || m_bo !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid ov=%b ir=%b d=%h bo=%b want 0 1 00 0", m_out_valid, m_in_ready, m_d, m_bo);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    op8_rand(0);
    op8_rand(1);
  endtask

  task automatic test_wide_parallel();
    logic [31:0] av, bv;
    logic        biv;
    logic [32:0] e;
    int          lat;
    for (int i = 0; i < 2000; i++) begin
      av = $urandom; bv = $urandom; biv = 1'($urandom);
      e = ref32(av, bv, biv);
      p_a = av; p_b = bv; p_bi = biv; p_in_valid = 1'b1;
      step();
      p_in_valid = 1'b0; p_a = $urandom; p_b = $urandom;
      lat = 0;
      while (!p_out_valid && lat < 50) begin step(); lat++; end
      total++;
      if (lat !== 1 || {p_bo, p_d} !== e) begin
        bad++;
        $display("FAIL wide_p lat=%0d bo,d=%h want lat=1 bo,d=%h", lat, {p_bo, p_d}, e);
      end
`ifdef AU_SUB_B_SER_OVF_EN
      total++;
      if (p_ovf !== ovf_ref(av[31], bv[31], e[31])) begin
        bad++;
        $display("FAIL wide_p_ovf got=%b", p_ovf);
      end
`endif
      repeat ($urandom_range(0, 2)) step();
      p_out_ready = 1'b1;
      step();
      p_out_ready = 1'b0;
    end
  endtask

  task automatic test_wide_serial();
    logic [31:0] av, bv;
    logic        biv;
    logic [32:0] e;
    int          lat;
    for (int i = 0; i < 300; i++) begin
      av = $urandom; bv = $urandom; biv = 1'($urandom);
      if (i == 0) begin av = 32'd0; bv = 32'd0; biv = 1'b1; end
      e = ref32(av, bv, biv);
      s_a = av; s_b = bv; s_bi = biv; s_in_valid = 1'b1;
      step();
      s_in_valid = 1'b0; s_a = $urandom; s_b = $urandom;
      lat = 0;
      while (!s_out_valid && lat < 80) begin step(); lat++; end
      total++;
      if (lat !== 32 || {s_bo, s_d} !== e) begin
        bad++;
        $display("FAIL wide_s lat=%0d bo,d=%h want lat=32 bo,d=%h", lat, {s_bo, s_d}, e);
      end
`ifdef AU_SUB_B_SER_OVF_EN
      total++;
      if (s_ovf !== ovf_ref(av[31], bv[31], e[31])) begin
        bad++;
        $display("FAIL wide_s_ovf got=%b", s_ovf);
      end
`endif
      repeat ($urandom_range(0, 2)) step();
      s_out_ready = 1'b1;
      step();
      s_out_ready = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_corners();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    test_wide_parallel();
    test_wide_serial();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
